// File: rtl/uc_multiciclo_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Contents: opcode constants, ALU-class prefix bit position, FSM state encoding
// and the raw control word produced by the decoder.
package uc_multiciclo_pkg;

  // Opcode constants (6-bit instruction opcode field)
  localparam logic [5:0] OP_LI   = 6'b000000;  // LI is 0000xx; low two bits are don't-care
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;

  // MSB set marks an ALU-class instruction (1ooo xx).
  localparam int ALU_BIT = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3,
    ERROR  = 3'd4
  } state_t;

  // Raw (ungated) datapath control word
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
  } ctrl_t;

endpackage

// File: rtl/uc_multiciclo_decode.sv
// uc_decode: purely combinational opcode/z -> raw control word plus HALT/illegal flags.
// Latency: zero cycles (combinational). No handshake; the FSM gates the outputs.
// Ports: opcode_i, z_i in; ctrl_o (s_inc/s_inm/we3/wez/op), is_halt_o, illegal_o out.
module uc_decode
  import uc_multiciclo_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  input  logic           z_i,
  output ctrl_t          ctrl_o,
  output logic           is_halt_o,
  output logic           illegal_o
);

  always_comb begin
    ctrl_o    = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'd0};
    is_halt_o = 1'b0;
    illegal_o = 1'b0;
    if (opcode_i[ALU_BIT]) begin
      ctrl_o.op  = opcode_i[4:2];
      ctrl_o.we3 = 1'b1;
      ctrl_o.wez = 1'b1;
    end else if (opcode_i[OPW-1:2] == OP_LI[OPW-1:2]) begin
      ctrl_o.we3   = 1'b1;
      ctrl_o.s_inm = 1'b1;
    end else begin
      case (opcode_i)
        OP_J:    ctrl_o.s_inc = 1'b0;
        // z is the flag registered by the previous instruction
        OP_JZ:   ctrl_o.s_inc = ~z_i;
        OP_JNZ:  ctrl_o.s_inc = z_i;
        OP_HALT: is_halt_o    = 1'b1;
        default: illegal_o    = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: FETCH/EXEC sequencing with run/step/halt, illegal trap, retire counter.
// Latency: 2 cycles per instruction (FETCH then EXEC); continuous run gives 1 instr / 2 cycles.
// Flow: run level or step pulse starts work from IDLE; step while busy is ignored.
// Ports: clk, reset (sync, active-high), Opcode, z, run, step in;
//        s_inc, s_inm, we3, wez, Op, pc_we (EXEC-gated), halted, err, busy, icount out.
module uc_multiciclo
  import uc_multiciclo_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  Opcode,
  input  logic            z,
  input  logic            run,
  input  logic            step,
  output logic            s_inc,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic [2:0]      Op,
  output logic            pc_we,
  output logic            halted,
  output logic            err,
  output logic            busy,
  output logic [CNTW-1:0] icount
);

  state_t          state_q, state_d;
  logic            step_latched_q, step_latched_d;
  logic [CNTW-1:0] icount_q, icount_d;

  ctrl_t ctrl;
  logic  is_halt;
  logic  illegal;

  uc_decode #(.OPW(OPW)) u_decode (
    .opcode_i  (Opcode),
    .z_i       (z),
    .ctrl_o    (ctrl),
    .is_halt_o (is_halt),
    .illegal_o (illegal)
  );

  // Reset is folded in so a reset landing on EXEC never fires a write.
  logic exec_act;
  assign exec_act = (state_q == EXEC) && !reset;

  always_comb begin
    state_d        = state_q;
    step_latched_d = step_latched_q;
    icount_d       = icount_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d        = FETCH;
          step_latched_d = 1'b0;   // run wins over a simultaneous step
        end else if (step) begin
          state_d        = FETCH;
          step_latched_d = 1'b1;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (is_halt) begin
          state_d = HALTED;
        end else if (illegal) begin
          state_d = ERROR;
        end else begin
          icount_d = icount_q + CNTW'(1);  // wraps silently
          if (run && !step_latched_q) begin
            state_d = FETCH;
          end else begin
            state_d        = IDLE;
            step_latched_d = 1'b0;
          end
        end
      end
      HALTED:  state_d = HALTED;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'd0;
    pc_we = 1'b0;
    if (exec_act) begin
      s_inc = ctrl.s_inc;
      s_inm = ctrl.s_inm;
      we3   = ctrl.we3;
      wez   = ctrl.wez;
      Op    = ctrl.op;
      pc_we = !is_halt && !illegal;
    end
  end

  assign halted = (state_q == HALTED);
  assign err    = (state_q == ERROR);
  assign busy   = (state_q == FETCH) || (state_q == EXEC);
  assign icount = icount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      step_latched_q <= 1'b0;
      icount_q       <= '0;
    end else begin
      state_q        <= state_d;
      step_latched_q <= step_latched_d;
      icount_q       <= icount_d;
    end
  end

endmodule
